spi_bitrev_ctrl: RTL and testbench

- Single-channel SPI master that sequences one complete transaction with the bitrev SPI slave peripheral.
- Accepts an 8-bit request byte and asserts SS.
- Generates 16 SCK periods: 8 to shift the byte out on MOSI, then 8 to capture the echoed bits from MISO.
- Returns the captured byte bit-reversed; sits between an internal requester (test harness or bus adapter) and the slave pins.

---
 rtl/spi_bitrev_pkg.sv | 22 ++
 rtl/spi_bitrev_sckgen.sv | 51 +++++
 rtl/spi_bitrev_ctrl.sv | 117 +++++++++++
 tb/tb_spi_bitrev_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_bitrev_pkg.sv
// Shared definitions for the bitrev SPI master: controller states, widths and default divider.
package spi_bitrev_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned NBITS       = 16;
  localparam int unsigned DEFAULT_DIV = 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    SETUP = ST_SETUP,
    SHIFT = ST_SHIFT,
    HOLD  = ST_HOLD,
    DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/spi_bitrev_sckgen.sv
// SCK generator: DIV-cycle half-period counter, registered sck and rise/fall edge strobes.
module spi_bitrev_sckgen
  import spi_bitrev_pkg::*;
#(
  parameter int unsigned DIV = DEFAULT_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic start,
  input  logic shift_en,
  input  logic last_bit,
  output logic half_tick,
  output logic rise_edge,
  output logic fall_edge,
  output logic sck
);

  localparam int unsigned     CNT_W   = $clog2(DIV) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  if (DIV == 0) begin : g_div_chk
    $fatal(1, "spi_bitrev_sckgen: DIV must be >= 1");
  end

  logic [CNT_W-1:0] cnt;

  assign half_tick = run && (cnt == CNT_MAX);
  // The first rise is launched from the end of SETUP; the rise after bit 15 is suppressed.
  assign rise_edge = half_tick && !sck && (start || (shift_en && !last_bit));
  assign fall_edge = half_tick && sck && shift_en;

  always_ff @(posedge clock) begin
    if (reset || !run || half_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sck <= 1'b0;
    end else if (rise_edge) begin
      sck <= 1'b1;
    end else if (fall_edge) begin
      sck <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_bitrev_ctrl.sv
// SPI master for the bitrev slave: sends one byte, captures the 8-bit echo and returns it bit-reversed.
module spi_bitrev_ctrl
  import spi_bitrev_pkg::*;
#(
  parameter int unsigned DIV = DEFAULT_DIV
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [BYTE_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [BYTE_W-1:0] rsp_data,
  output logic              busy,
  output logic              spi_sck,
  output logic              spi_ss_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  state_e            state;
  logic [BYTE_W-2:0] tx;
  logic [BYTE_W-1:0] rx;
  logic [3:0]        idx;
  logic              run;
  logic              last_bit;
  logic              half_tick;
  logic              rise_edge;
  logic              fall_edge;

  assign run       = (state == SETUP) || (state == SHIFT) || (state == HOLD);
  assign last_bit  = (idx == 4'(NBITS - 1));
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  spi_bitrev_sckgen #(
    .DIV(DIV)
  ) u_sckgen (
    .clock    (clock),
    .reset    (reset),
    .run      (run),
    .start    (state == SETUP),
    .shift_en (state == SHIFT),
    .last_bit (last_bit),
    .half_tick(half_tick),
    .rise_edge(rise_edge),
    .fall_edge(fall_edge),
    .sck      (spi_sck)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      spi_ss_n  <= 1'b1;
      spi_mosi  <= 1'b1;
      tx        <= '0;
      rx        <= '0;
      idx       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            tx       <= req_data[BYTE_W-2:0];
            rx       <= '0;
            spi_mosi <= req_data[BYTE_W-1];
            spi_ss_n <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (half_tick) begin
            idx   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (rise_edge) begin
            idx <= idx + 4'd1;
          end
          // tx back-fills with ones so mosi idles high through the receive half.
          if (fall_edge) begin
            spi_mosi <= tx[BYTE_W-2];
            tx       <= {tx[BYTE_W-3:0], 1'b1};
            if (idx[3]) begin
              rx[idx[2:0]] <= spi_miso;
            end
          end
          if (half_tick && !spi_sck && last_bit) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (half_tick) begin
            spi_ss_n <= 1'b1;
            spi_mosi <= 1'b1;
            rsp_data <= rx;
            state    <= DONE;
          end
        end
        DONE: begin
          // rsp_valid rises one cycle into DONE, giving the 34*DIV+1 accept-to-valid latency.
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            rsp_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bitrev_ctrl.sv
// Directed bench for spi_bitrev_ctrl at DIV=1 and DIV=3 with an attached bitrev slave model and a response scoreboard.
module tb_spi_bitrev_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset;
  logic [7:0]      req_data;
  logic [1:0]      req_valid, rsp_ready, noise;
  logic [1:0]      req_ready_v, rsp_valid_v, busy_v, sck_v, ssn_v, mosi_v;
  logic [1:0][7:0] rsp_v, rises_v, mseq_v, mhi_v;
  logic [1:0][15:0] perr_v;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] sb_q[$];

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned D = (g == 0) ? 1 : 3;
    logic        miso  = 1'b1;
    logic [7:0]  cnt   = '0;
    logic [7:0]  sh    = '0;
    logic [7:0]  rises = '0;
    logic [7:0]  mseq  = '0;
    logic [7:0]  mhi   = '0;
    logic [15:0] run   = '0;
    logic [15:0] perr  = '0;
    logic        prev  = 1'b0;

    spi_bitrev_ctrl #(.DIV(D)) u_dut (
      .clock    (clock),
      .reset    (reset),
      .req_valid(req_valid[g]),
      .req_ready(req_ready_v[g]),
      .req_data (req_data),
      .rsp_valid(rsp_valid_v[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_data (rsp_v[g]),
      .busy     (busy_v[g]),
      .spi_sck  (sck_v[g]),
      .spi_ss_n (ssn_v[g]),
      .spi_mosi (mosi_v[g]),
      .spi_miso (miso)
    );

    // Slave: shifts in 8 bits at sck rises, then echoes them MSB first.
    always @(posedge sck_v[g], posedge ssn_v[g], negedge ssn_v[g]) begin
      if (ssn_v[g] !== 1'b0) begin
        miso = 1'b1;
      end else if (sck_v[g] !== 1'b1) begin
        cnt = '0; rises = '0; mseq = '0; mhi = '0;
        miso = !noise[g];
      end else begin
        rises = rises + 8'd1;
        if (cnt < 8) begin
          sh   = {sh[6:0], mosi_v[g]};
          mseq = {mseq[6:0], mosi_v[g]};
          miso = !noise[g];
        end else begin
          if (mosi_v[g] !== 1'b1) mhi = mhi + 8'd1;
          miso = sh[~cnt[2:0]];
        end
        cnt = cnt + 8'd1;
      end
    end

    // Every completed sck phase while selected must last exactly D cycles.
    always @(negedge clock) begin
      if (ssn_v[g] !== 1'b0) begin
        run  = '0;
        prev = 1'b0;
      end else begin
        if (sck_v[g] !== prev) begin
          if (run != 16'(D)) perr = perr + 16'd1;
          run = 16'd1;
        end else begin
          run = run + 16'd1;
        end
        prev = sck_v[g];
      end
    end

    assign rises_v[g] = rises;
    assign mseq_v[g]  = mseq;
    assign mhi_v[g]   = mhi;
    assign perr_v[g]  = perr;
  end

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task tick;
    @(posedge clock);
    #1;
  endtask

  task automatic accept(input int u, input logic [7:0] d, output int n);
    logic was;
    req_data     = d;
    req_valid[u] = 1'b1;
    n = 0;
    do begin
      was = req_ready_v[u];
      tick();
      n++;
    end while (!was && n < 200);
    chk("accept", {31'b0, was}, 1);
    sb_q.push_back(rev8(d));
  endtask

  task automatic wait_rsp(input int u, input int exp_lat, input string tag);
    int c;
    c = 0;
    while (rsp_valid_v[u] !== 1'b1 && c < 500) begin
      tick();
      c++;
    end
    chk({tag, "_lat"}, c, exp_lat);
    chk({tag, "_vld"}, {31'b0, rsp_valid_v[u]}, 1);
  endtask

  task automatic take_rsp(input int u, input string tag);
    logic [7:0] exp;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
    chk({tag, "_data"}, {24'b0, rsp_v[u]}, {24'b0, exp});
    rsp_ready[u] = 1'b1;
    tick();
    chk({tag, "_idle"}, {31'b0, req_ready_v[u]}, 1);
    chk({tag, "_drop"}, {31'b0, rsp_valid_v[u]}, 0);
  endtask

  initial begin
    int   n;
    logic seen;
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    noise     = '0;
    req_data  = '0;
    repeat (3) tick();
    for (int u = 0; u < 2; u++) begin
      chk("rst_ssn",   {31'b0, ssn_v[u]},       1);
      chk("rst_sck",   {31'b0, sck_v[u]},       0);
      chk("rst_mosi",  {31'b0, mosi_v[u]},      1);
      chk("rst_ready", {31'b0, req_ready_v[u]}, 1);
      chk("rst_vld",   {31'b0, rsp_valid_v[u]}, 0);
      chk("rst_busy",  {31'b0, busy_v[u]},      0);
      chk("rst_data",  {24'b0, rsp_v[u]},       0);
    end
    reset = 1'b0;
    tick();

    // Abort mid-SHIFT with a 3-cycle reset.
    accept(0, 8'hA5, n);
    req_valid[0] = 1'b0;
    void'(sb_q.pop_back());
    repeat (10) tick();
    chk("abort_busy", {31'b0, busy_v[0]}, 1);
    chk("abort_ssn0", {31'b0, ssn_v[0]},  0);
    reset = 1'b1;
    tick();
    chk("abort_ssn",   {31'b0, ssn_v[0]},       1);
    chk("abort_sck",   {31'b0, sck_v[0]},       0);
    chk("abort_mosi",  {31'b0, mosi_v[0]},      1);
    chk("abort_vld",   {31'b0, rsp_valid_v[0]}, 0);
    chk("abort_ready", {31'b0, req_ready_v[0]}, 1);
    repeat (2) tick();
    reset = 1'b0;
    seen  = 1'b0;
    repeat (60) begin
      tick();
      seen = seen | rsp_valid_v[0] | !ssn_v[0];
    end
    chk("abort_quiet", {31'b0, seen}, 0);

    // DIV=1, 0x01 with rsp_ready held high.
    rsp_ready[0] = 1'b1;
    accept(0, 8'h01, n);
    req_valid[0] = 1'b0;
    wait_rsp(0, 35, "d1_01");
    chk("d1_01_rises", {24'b0, rises_v[0]}, 16);
    take_rsp(0, "d1_01");

    // DIV=1, 0xB4: MOSI pattern on the first 8 rises, high afterwards.
    accept(0, 8'hB4, n);
    req_valid[0] = 1'b0;
    wait_rsp(0, 35, "d1_b4");
    chk("d1_b4_mosi",  {24'b0, mseq_v[0]},  32'hB4);
    chk("d1_b4_mhi",   {24'b0, mhi_v[0]},   0);
    chk("d1_b4_rises", {24'b0, rises_v[0]}, 16);
    take_rsp(0, "d1_b4");

    // DIV=3, 0xF0, slave drives 0 during bits 0..7 which must be ignored.
    noise[1]     = 1'b1;
    rsp_ready[1] = 1'b1;
    accept(1, 8'hF0, n);
    req_valid[1] = 1'b0;
    wait_rsp(1, 103, "d3_f0");
    chk("d3_f0_rises", {24'b0, rises_v[1]}, 16);
    chk("d3_f0_mosi",  {24'b0, mseq_v[1]},  32'hF0);
    take_rsp(1, "d3_f0");

    // Back-to-back with req_valid held high and a 5-cycle response stall.
    rsp_ready[0] = 1'b0;
    accept(0, 8'h12, n);
    req_data = 8'hC3;
    repeat (10) tick();
    chk("b2b_busy",  {31'b0, busy_v[0]},      1);
    chk("b2b_noacc", {31'b0, req_ready_v[0]}, 0);
    wait_rsp(0, 25, "b2b1");
    for (int i = 0; i < 5; i++) begin
      chk("stall_data",  {24'b0, rsp_v[0]},       32'h48);
      chk("stall_vld",   {31'b0, rsp_valid_v[0]}, 1);
      chk("stall_ready", {31'b0, req_ready_v[0]}, 0);
      chk("stall_ssn",   {31'b0, ssn_v[0]},       1);
      tick();
    end
    take_rsp(0, "b2b1");
    chk("b2b_gap_ssn", {31'b0, ssn_v[0]}, 1);
    accept(0, 8'hC3, n);
    chk("b2b_gap", n, 1);
    chk("b2b_sel", {31'b0, ssn_v[0]}, 0);
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    wait_rsp(0, 35, "b2b2");
    take_rsp(0, "b2b2");

    chk("phase_d1", {16'b0, perr_v[0]}, 0);
    chk("phase_d3", {16'b0, perr_v[1]}, 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
